// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: instruction-memory port, decoder handshake, next-PC inputs and error status.
// Signal names follow the memory/decoder port names; "master" is the fetch unit, "slave" is its environment.
interface inst_fetch_if;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic [31:0] MEM_INST;
    logic        INST_ENB;
    logic [31:0] INST_PC;
    logic        DEC_RDY;
    logic        NEXT_VALID;
    logic        BR_TAKEN;
    logic [2:0]  PC_MUX_SELECT;
    logic [31:0] IMM;
    logic [31:0] ALU_RESULT;
    logic        FETCH_ERR;
    logic [1:0]  ERR_CODE;

    modport master (
        output MEM_REQ, MEM_ADDR, MEM_INST, INST_ENB, INST_PC, FETCH_ERR, ERR_CODE,
        input  MEM_ACK, MEM_RDATA, DEC_RDY, NEXT_VALID, BR_TAKEN, PC_MUX_SELECT, IMM, ALU_RESULT
    );

    modport slave (
        input  MEM_REQ, MEM_ADDR, MEM_INST, INST_ENB, INST_PC, FETCH_ERR, ERR_CODE,
        output MEM_ACK, MEM_RDATA, DEC_RDY, NEXT_VALID, BR_TAKEN, PC_MUX_SELECT, IMM, ALU_RESULT
    );
endinterface

// File: rtl/inst_fetch.sv
// Non-pipelined instruction fetch: FETCH -> ISSUE -> EXEC loop with one instruction in flight,
// memory timeout, redirect target checking and a sticky error state left only through reset.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    inst_fetch_if.master bus,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [7:0]  cnt_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_enb_q;
    logic        mem_req_q;
    logic        err_q;
    logic [1:0]  code_q;

    logic [31:0] pc_d;
    logic [1:0]  code_d;

    // Redirect target and its legality; only consumed on NEXT_VALID in EXEC.
    always_comb begin
        pc_d   = inst_pc_q + 32'd4;
        code_d = 2'd0;
        if (bus.BR_TAKEN) begin
            case (bus.PC_MUX_SELECT)
                3'd0:    pc_d = inst_pc_q + bus.IMM;
                3'd1:    pc_d = bus.ALU_RESULT & 32'hFFFF_FFFE;
                default: code_d = 2'd3;
            endcase
        end
        if (code_d == 2'd0 && pc_d[1:0] != 2'b00) begin
            code_d = 2'd2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            cnt_q      <= 8'd0;
            inst_q     <= 32'd0;
            inst_pc_q  <= 32'd0;
            inst_enb_q <= 1'b0;
            mem_req_q  <= 1'b1;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // An ACK in the last allowed cycle still counts as a response.
                    if (bus.MEM_ACK) begin
                        inst_q     <= bus.MEM_RDATA;
                        inst_pc_q  <= pc_q;
                        inst_enb_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= S_ISSUE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        code_q    <= 2'd1;
                        state_q   <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (bus.DEC_RDY) begin
                        inst_enb_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (bus.NEXT_VALID) begin
                        if (code_d != 2'd0) begin
                            err_q   <= 1'b1;
                            code_q  <= code_d;
                            state_q <= S_ERROR;
                        end else begin
                            pc_q      <= pc_d;
                            cnt_q     <= 8'd0;
                            mem_req_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= S_ERROR;
                end
            endcase
        end
    end

    // MEM_REQ is forced low while reset is held, independent of the registered value.
    assign bus.MEM_REQ   = mem_req_q & ~RST;
    assign bus.MEM_ADDR  = pc_q;
    assign bus.MEM_INST  = inst_q;
    assign bus.INST_ENB  = inst_enb_q;
    assign bus.INST_PC   = inst_pc_q;
    assign bus.FETCH_ERR = err_q;
    assign bus.ERR_CODE  = code_q;
    assign dbg_state_o   = state_q;

endmodule
